// File: rtl/common.sv
// rtl/common.sv - shared constants and state type for the decision-bit stack backtracker
//
// Purpose: stack geometry shared by the backtracker and the stack instance,
//          plus the backtrack controller state encoding.
// Contents: bool_stack_size, width_bool_stack_size, level_full, bt_state_t.

package common;

  localparam int bool_stack_size       = 8;
  localparam int width_bool_stack_size = 3;

  // Depth value meaning "every stack slot is occupied".
  localparam logic [width_bool_stack_size:0] level_full =
    (width_bool_stack_size + 1)'(bool_stack_size);

  typedef enum logic [2:0] {
    IDLE,
    POP,
    CHECK,
    PUSH_FLIP,
    DONE,
    UNSAT
  } bt_state_t;

endpackage

// File: rtl/dpll_backtrack.sv
// rtl/dpll_backtrack.sv - chronological backtracking controller for the decision-bit stack
//
// Purpose: pushes solver decisions onto the stack; on a conflict pops entries
//          until one whose alternate polarity is untried, then pushes it flipped.
//          Reports unsat when every level has been exhausted.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   dec_valid/dec_val     decision offer and its polarity; dec_ready accepts
//   conflict              backtrack request, sampled only in IDLE
//   bt_busy, bt_done      backtrack in progress / completion pulse
//   bt_val/level/pops     flipped value, resulting depth, entries popped
//   unsat, overflow       sticky status flags
//   stk_wr_en/din/pop     stack controls; stk_dout/full/empty stack outputs

module dpll_backtrack
  import common::*;
(
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             dec_valid,
  input  logic                             dec_val,
  output logic                             dec_ready,
  input  logic                             conflict,
  output logic                             bt_busy,
  output logic                             bt_done,
  output logic                             bt_val,
  output logic [width_bool_stack_size:0]   bt_level,
  output logic [width_bool_stack_size:0]   bt_pops,
  output logic                             unsat,
  output logic                             overflow,
  output logic                             stk_wr_en,
  output logic                             stk_din,
  output logic                             stk_pop,
  input  logic                             stk_dout,
  input  logic                             stk_full,
  input  logic                             stk_empty
);

  localparam int W = width_bool_stack_size;

  bt_state_t                  state, state_next;
  logic [W:0]                 level;
  logic [bool_stack_size-1:0] flipped;
  logic                       popped;
  logic                       dec_accept;
  logic [W-1:0]               idx;

  // The stack's own flags lag a pop by one cycle; level is the authority.
  logic unused_flags;
  assign unused_flags = stk_full | stk_empty;

  // Only read when level < bool_stack_size, so the truncation is safe.
  assign idx        = level[W-1:0];
  assign dec_accept = dec_valid && dec_ready;
  assign bt_busy    = (state != IDLE) && (state != UNSAT);
  assign bt_done    = (state == DONE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      level    <= '0;
      flipped  <= '0;
      popped   <= 1'b0;
      bt_val   <= 1'b0;
      bt_level <= '0;
      bt_pops  <= '0;
      unsat    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (dec_accept) begin
            flipped[idx] <= 1'b0;
            level        <= level + 1'b1;
          end
          if (dec_valid && (level == level_full))
            overflow <= 1'b1;
          if (conflict && (level != '0))
            bt_pops <= '0;
        end
        POP: begin
          level   <= level - 1'b1;
          bt_pops <= bt_pops + 1'b1;
        end
        CHECK: popped <= stk_dout;
        PUSH_FLIP: begin
          flipped[idx] <= 1'b1;
          level        <= level + 1'b1;
          bt_val       <= ~popped;
          bt_level     <= level + 1'b1;
        end
        UNSAT: unsat <= 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    dec_ready  = 1'b0;
    stk_wr_en  = 1'b0;
    stk_din    = 1'b0;
    stk_pop    = 1'b0;
    case (state)
      IDLE: begin
        // Gated by reset so nothing is accepted while the stack is held in reset.
        dec_ready = !reset && !conflict && (level < level_full);
        if (conflict) begin
          state_next = (level == '0) ? UNSAT : POP;
        end else if (dec_valid && dec_ready) begin
          stk_wr_en = 1'b1;
          stk_din   = dec_val;
        end
      end
      POP: begin
        stk_pop    = 1'b1;
        state_next = CHECK;
      end
      CHECK: begin
        if (!flipped[idx])
          state_next = PUSH_FLIP;
        else if (level == '0)
          state_next = UNSAT;
        else
          state_next = POP;
      end
      PUSH_FLIP: begin
        stk_wr_en  = 1'b1;
        stk_din    = ~popped;
        state_next = DONE;
      end
      DONE:    state_next = IDLE;
      UNSAT:   state_next = UNSAT;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/dpll_backtrack.md
# dpll_backtrack

Chronological backtracking controller for the decision-bit stack. It is the initiator side of the stack's push/pop interface. It pushes new decisions on request from the solver core. On a conflict it pops decisions until it finds one whose opposite polarity has not been tried, then pushes the flipped value. It sits between the solver core and the stack instance in the parent, and reports UNSAT when the stack is exhausted.

## Interface
- Parameters: none. Depth is `common::bool_stack_size` and index width is `common::width_bool_stack_size` (W).
- `clock` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `dec_valid` in 1: solver offers a new decision.
- `dec_val` in 1: polarity of the offered decision.
- `dec_ready` out 1: decision accepted this cycle when high together with `dec_valid`.
- `conflict` in 1: backtrack request, sampled in IDLE.
- `bt_busy` out 1: high in every state except IDLE and UNSAT.
- `bt_done` out 1: one-cycle pulse when a backtrack completes.
- `bt_val` out 1: flipped value now on top of the stack; valid with `bt_done`, held until the next `bt_done`.
- `bt_level` out W+1: stack depth after the backtrack; valid with `bt_done`.
- `bt_pops` out W+1: entries removed during the backtrack, including the re-pushed one; valid with `bt_done`.
- `unsat` out 1: sticky.
- `overflow` out 1: sticky; a decision was offered while depth == `bool_stack_size`.
- `stk_wr_en` out 1, `stk_din` out 1, `stk_pop` out 1: stack controls.
- `stk_dout` in 1, `stk_full` in 1, `stk_empty` in 1: stack outputs. `stk_dout` is valid the cycle after `stk_pop`. `stk_empty`/`stk_full` are not used for control.

## Operation
- Internal `level` (W+1 bits, 0..`bool_stack_size`) mirrors stack depth and is authoritative. The stack's empty flag lags by one pop and must not terminate backtracking.
- Internal `flipped[bool_stack_size]`: one bit per level, set once that level's alternate polarity has been tried.
- States:
  - IDLE: accept decisions or start a backtrack.
  - POP: drive `stk_pop` for one cycle.
  - CHECK: examine the popped entry.
  - PUSH_FLIP: push the flipped value.
  - DONE: pulse `bt_done`.
  - UNSAT: absorbing.
- IDLE, decision path:
  - `dec_ready` = IDLE && !`conflict` && `level` < `bool_stack_size`.
  - On `dec_valid`&&`dec_ready`: `stk_wr_en`=1 and `stk_din`=`dec_val` combinationally; `flipped[level]`<=0; `level`++.
- IDLE, full stack: `dec_valid` while `level`==`bool_stack_size` sets `overflow`, and nothing is pushed.
- IDLE, conflict path:
  - `conflict` with `level`==0 goes to UNSAT.
  - Otherwise clear the `bt_pops` counter and go to POP.
  - `conflict` beats `dec_valid` in the same cycle; the decision is not accepted.
- POP: `stk_pop`=1; `level`--; `bt_pops`++; go to CHECK.
- CHECK (`stk_dout` valid):
  - If `flipped[level]`==0, go to PUSH_FLIP.
  - Else if `level`==0, go to UNSAT.
  - Else go to POP.
- PUSH_FLIP: `stk_wr_en`=1, `stk_din`=~`stk_dout` (registered in CHECK); `flipped[level]`<=1; `level`++; latch `bt_val`; go to DONE.
- DONE: `bt_done`=1, `bt_level`=`level`; go to IDLE.
- UNSAT: `unsat`=1; `dec_ready`=0; `conflict` and `dec_valid` are ignored until reset.
- `stk_wr_en` and `stk_pop` are never high in the same cycle.
- `conflict` outside IDLE is ignored. The solver holds it or re-issues it after `bt_done`.

## Timing
- Reset values:
  - `dec_ready`=0 while in reset, then follows its IDLE equation.
  - All other outputs 0: `bt_busy`, `bt_done`, `bt_val`, `bt_level`, `bt_pops`, `unsat`, `overflow`, `stk_wr_en`, `stk_din`, `stk_pop`.
  - `level`=0, `flipped`=0, state IDLE.
- Decision push: zero-latency accept; the stack sees the push on the same edge.
- Backtrack where the top entry is unflipped: `conflict` sampled at edge 0, `stk_pop` in cycle 1, CHECK in cycle 2, push in cycle 3, `bt_done` in cycle 4.
- Each additional already-flipped level adds 2 cycles.
- UNSAT is entered 2 cycles after the last pop. `unsat` rises the cycle after entry.
- Reset mid-backtrack returns to IDLE asynchronously. The parent resets the stack with the same `reset`.

## Structure
- `common`: `bool_stack_size`, `width_bool_stack_size`, and a new `bt_state_t` enum (IDLE, POP, CHECK, PUSH_FLIP, DONE, UNSAT).
- No sub-module. `Stack_bool` is instantiated next to this block in the parent, with ports wired one-to-one.

## Test plan
All scenarios use `bool_stack_size`=8.
- Push decisions 1,0,1, then `conflict` -> `stk_pop` once; push of 0; `bt_done` at cycle 4, `bt_val`=0, `bt_level`=3, `bt_pops`=1.
- Repeat `conflict` immediately after `bt_done` -> top is flipped, so pops twice; `bt_val`=1, `bt_level`=2, `bt_pops`=2; `bt_done` at cycle 6.
- Single decision 0: conflict, then conflict again -> first gives `bt_val`=1, `bt_level`=1; second drives `unsat`=1 with `level`=0, and `dec_ready` stays 0 afterwards.
- Push 8 decisions, then offer a 9th -> `overflow`=1, no `stk_wr_en`, `level` stays 8.
- `dec_valid` and `conflict` in the same IDLE cycle -> no push; backtrack proceeds on the prior contents.
- Assert `reset` during POP -> all outputs 0 at once; `level`=0; a subsequent `conflict` drives UNSAT.
